// File: rtl/mem_sdu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_sdu_ctrl_pkg                                                     |
// | Shared types and defaults for the SDU memory controller.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_sdu_ctrl_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_DUMP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_sdu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_sdu_ctrl_if                                                      |
// | CPU store, SDU command/write/dump and memory port bundle.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_sdu_ctrl_if
  import mem_sdu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_cnt;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;

  logic              busy;
  logic              done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [31:0]       mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  // Controller side
  modport slave (
    input  cpu_we, cpu_addr, cpu_din,
    input  cmd_valid, cmd_op, cmd_base, cmd_cnt,
    input  wr_valid, wr_data, rd_ready, mem_rd_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    output mem_we, mem_addr, mem_din, mem_rd_addr
  );

  // CPU / SDU / memory side
  modport master (
    output cpu_we, cpu_addr, cpu_din,
    output cmd_valid, cmd_op, cmd_base, cmd_cnt,
    output wr_valid, wr_data, rd_ready, mem_rd_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    input  mem_we, mem_addr, mem_din, mem_rd_addr
  );

endinterface
`default_nettype wire

// File: rtl/mem_sdu_ctrl_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_sdu_wr_arb                                                       |
// | Memory write-port mux; CPU stores always win over SDU block writes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_sdu_wr_arb
  import mem_sdu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire               cpu_we,
  input  wire  [ADDR_W-1:0] cpu_addr,
  input  wire  [DATA_W-1:0] cpu_din,
  input  wire               sdu_req,
  input  wire  [ADDR_W-1:0] sdu_addr,
  input  wire  [DATA_W-1:0] sdu_din,
  output logic              grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din
);

  always_comb begin
    grant    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_we) begin
      mem_we   = 1'b1;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end else if (sdu_req) begin
      grant    = 1'b1;
      mem_we   = 1'b1;
      mem_addr = sdu_addr;
      mem_din  = sdu_din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_sdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_sdu_ctrl                                                         |
// | SDU block-write / block-dump controller for the 1024x32 data memory. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_sdu_ctrl
  import mem_sdu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input wire            clk,
  input wire            rst,
  mem_sdu_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W:0]   r_idx;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic [ADDR_W-1:0] w_addr;
  logic              w_more;
  logic              w_sdu_req;
  logic              w_grant;
  logic              w_load;
  logic              w_take;

  // idx carries one extra bit so a full 2^ADDR_W-word command still ends
  assign w_addr    = r_base + r_idx[ADDR_W-1:0];
  assign w_more    = (r_idx <= {1'b0, r_cnt});
  assign w_sdu_req = (r_state == ST_WRITE) && bus.wr_valid;
  assign w_load    = (r_state == ST_DUMP) && w_more && (!r_rd_valid || bus.rd_ready);
  assign w_take    = r_rd_valid && bus.rd_ready;

  mem_sdu_wr_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_arb (
    .cpu_we   (bus.cpu_we),
    .cpu_addr (bus.cpu_addr),
    .cpu_din  (bus.cpu_din),
    .sdu_req  (w_sdu_req),
    .sdu_addr (w_addr),
    .sdu_din  (bus.wr_data),
    .grant    (w_grant),
    .mem_we   (bus.mem_we),
    .mem_addr (bus.mem_addr),
    .mem_din  (bus.mem_din)
  );

  assign bus.wr_ready    = w_grant;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = r_rd_data;
  assign bus.mem_rd_addr = (r_state == ST_DUMP) ? {{(32-ADDR_W){1'b0}}, w_addr} : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.cmd_ready = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_state_nxt = (bus.cmd_op == OP_DUMP) ? ST_DUMP : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_grant && (r_idx == {1'b0, r_cnt})) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DUMP: begin
        // Finish only when the final word has been handed over
        if (w_take && !w_more) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.cmd_valid) begin
        r_base <= bus.cmd_base;
        r_cnt  <= bus.cmd_cnt;
        r_idx  <= '0;
      end else if (w_grant || w_load) begin
        r_idx <= r_idx + (ADDR_W+1)'(1);
      end

      // Captures the pre-write value when the CPU stores to the same word
      if (w_load) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= bus.mem_rd_data;
      end else if (w_take) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
